// File: rtl/program_sequencer.sv
// program_sequencer: repeatedly fetches, checks for HALT, issues and waits for execution
// until HALT, abort, wait timeout or the per-run instruction limit ends the run.
//  state      | meaning
//  IDLE       | waiting for start
//  FETCH      | one-cycle fetch request
//  WAIT_FETCH | waiting for fetch_done_i / opcode
//  ISSUE      | one-cycle execution start
//  WAIT_EXEC  | waiting for exec_done_i
//  FINISH     | normal end of run, done pulse
//  FAULT      | faulted end of run, done pulse with error
module program_sequencer #(
  parameter int unsigned          OPCODE_W    = 5,
  parameter logic [OPCODE_W-1:0]  HALT_OPCODE = '0,
  parameter int unsigned          MAX_INSTR   = 1024,
  parameter int unsigned          TIMEOUT     = 65535
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                fetch_en_o,
  input  logic                fetch_done_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  output logic                exec_start_o,
  input  logic                exec_done_i,
  output logic                latch_o,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code,
  output logic [15:0]         instr_count
);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_FETCH, ISSUE, WAIT_EXEC, FINISH, FAULT
  } state_t;

  localparam logic [1:0]  ERR_NONE    = 2'd0;
  localparam logic [1:0]  ERR_TIMEOUT = 2'd1;
  localparam logic [1:0]  ERR_LIMIT   = 2'd2;
  localparam logic [1:0]  ERR_ABORT   = 2'd3;
  localparam logic [16:0] TO_TC       = 17'(TIMEOUT) - 17'd1;
  localparam logic [15:0] MAX_CNT     = 16'(MAX_INSTR);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  code_nxt;
  logic [15:0] wcnt;
  logic        timeout_hit;
  logic        exec_ok;
  logic        run_state;

  // Counter value after this cycle's increment has reached TIMEOUT-1
  assign timeout_hit = ({1'b0, wcnt} + 17'd1) >= TO_TC;
  assign run_state   = (state == FETCH) || (state == WAIT_FETCH) ||
                       (state == ISSUE) || (state == WAIT_EXEC);
  assign exec_ok     = (state == WAIT_EXEC) && exec_done_i && !abort;
  assign latch_o     = (state == WAIT_FETCH) && !abort && fetch_done_i &&
                       (opcode_i != HALT_OPCODE);

  always_comb begin
    state_nxt = state;
    code_nxt  = ERR_NONE;
    case (state)
      IDLE:       if (start) state_nxt = FETCH;
      FETCH:      state_nxt = WAIT_FETCH;
      WAIT_FETCH: begin
        if (fetch_done_i) begin
          state_nxt = (opcode_i == HALT_OPCODE) ? FINISH : ISSUE;
        end else if (timeout_hit) begin
          state_nxt = FAULT;
          code_nxt  = ERR_TIMEOUT;
        end
      end
      ISSUE:      state_nxt = WAIT_EXEC;
      WAIT_EXEC: begin
        if (exec_done_i) begin
          if (instr_count + 16'd1 == MAX_CNT) begin
            state_nxt = FAULT;
            code_nxt  = ERR_LIMIT;
          end else begin
            state_nxt = FETCH;
          end
        end else if (timeout_hit) begin
          state_nxt = FAULT;
          code_nxt  = ERR_TIMEOUT;
        end
      end
      FINISH:     state_nxt = IDLE;
      FAULT:      state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
    // abort outranks any done or timeout in the running states
    if (abort && run_state) begin
      state_nxt = FAULT;
      code_nxt  = ERR_ABORT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wcnt         <= '0;
      instr_count  <= '0;
      error        <= 1'b0;
      err_code     <= ERR_NONE;
      fetch_en_o   <= 1'b0;
      exec_start_o <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      fetch_en_o   <= (state_nxt == FETCH);
      exec_start_o <= (state_nxt == ISSUE);
      busy         <= (state_nxt != IDLE);
      done         <= (state_nxt == FINISH) || (state_nxt == FAULT);

      if (state == FETCH || state == ISSUE) begin
        wcnt <= '0;
      end else if (state == WAIT_FETCH || state == WAIT_EXEC) begin
        wcnt <= wcnt + 16'd1;
      end

      if (state == IDLE && start) begin
        instr_count <= '0;
        error       <= 1'b0;
        err_code    <= ERR_NONE;
      end else begin
        if (exec_ok) instr_count <= instr_count + 16'd1;
        if (state_nxt == FAULT && state != FAULT) begin
          error    <= 1'b1;
          err_code <= code_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: stimulus pushes expected end-of-run results,
// a negedge monitor pops and compares them on every done pulse.
module tb_program_sequencer;
  localparam int         OW   = 5;
  localparam logic [4:0] HALT = 5'h00;
  localparam int         MAXI = 4;
  localparam int         TMO  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        fetch_done_i = 1'b0;
  logic        exec_done_i = 1'b0;
  logic [4:0]  opcode_i = 5'h00;
  logic        fetch_en_o, exec_start_o, latch_o, busy, done, error;
  logic [1:0]  err_code;
  logic [15:0] instr_count;

  program_sequencer #(
    .OPCODE_W(OW), .HALT_OPCODE(HALT), .MAX_INSTR(MAXI), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .fetch_en_o(fetch_en_o), .fetch_done_i(fetch_done_i), .opcode_i(opcode_i),
    .exec_start_o(exec_start_o), .exec_done_i(exec_done_i), .latch_o(latch_o),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       err;
    logic [1:0] code;
    int         cnt;
    int         nf;
    int         ne;
    int         dcyc;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int nf = 0;
  int ne = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: counts request pulses per run and checks each done against the scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      nf = 0;
      ne = 0;
    end else begin
      if (fetch_en_o) nf++;
      if (exec_start_o) ne++;
      if (done) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("run_error", error, e.err);
          chk("run_err_code", err_code, e.code);
          chk("run_instr_count", instr_count, e.cnt);
          chk("run_fetch_pulses", nf, e.nf);
          chk("run_exec_pulses", ne, e.ne);
          chk("run_done_cycle", cyc, e.dcyc);
        end
        nf = 0;
        ne = 0;
      end
    end
  end

  task automatic wait_fetch();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!fetch_en_o && k < 50);
    chk("fetch_en_seen", fetch_en_o, 1);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", done, 1);
  endtask

  // Called at the FETCH negedge; leaves fetch_done_i high for the caller to drop
  task automatic do_fetch(input logic [4:0] op, input int lat);
    repeat (lat - 1) @(negedge clk);
    fetch_done_i = 1'b1;
    opcode_i     = op;
    #1;
    chk("latch_o", latch_o, (op != HALT));
  endtask

  // Called at the ISSUE negedge; leaves exec_done_i high for the caller to drop
  task automatic do_exec(input int lat);
    repeat (lat - 1) @(negedge clk);
    exec_done_i = 1'b1;
  endtask

  task automatic run_one(input logic [4:0] op, input int flat, input int elat);
    do_fetch(op, flat);
    @(negedge clk);
    fetch_done_i = 1'b0;
    chk("exec_start_timing", exec_start_o, 1);
    do_exec(elat);
    @(negedge clk);
    exec_done_i = 1'b0;
  endtask

  initial begin
    logic [4:0] ops [3];
    int c;
    ops[0] = 5'h03; ops[1] = 5'h11; ops[2] = 5'h1f;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_instr_count", instr_count, 0);
    chk("rst_fetch_en", fetch_en_o, 0);
    chk("rst_exec_start", exec_start_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Three instructions then HALT, fetch latency 4, exec latency 10
    start = 1'b1;
    wait_fetch();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < 3; i++) begin
      run_one(ops[i], 4, 10);
      chk("refetch_timing", fetch_en_o, 1);
    end
    do_fetch(HALT, 4);
    sbq.push_back('{1'b0, 2'd0, 3, 4, 3, cyc + 1});
    @(negedge clk);
    fetch_done_i = 1'b0;
    @(negedge clk);
    chk("busy_after_finish", busy, 0);
    chk("count_held", instr_count, 3);

    // HALT as the first opcode
    start = 1'b1;
    wait_fetch();
    start = 1'b0;
    do_fetch(HALT, 3);
    sbq.push_back('{1'b0, 2'd0, 0, 1, 0, cyc + 1});
    @(negedge clk);
    fetch_done_i = 1'b0;
    chk("halt_no_exec_start", exec_start_o, 0);
    @(negedge clk);
    chk("busy_after_halt", busy, 0);

    // fetch_done_i never arrives
    start = 1'b1;
    wait_fetch();
    start = 1'b0;
    sbq.push_back('{1'b1, 2'd1, 0, 1, 0, cyc + TMO});
    @(negedge clk);
    wait_done();
    @(negedge clk);

    // exec_done_i never arrives: done 16 cycles after ISSUE, then restart clears error
    start = 1'b1;
    wait_fetch();
    start = 1'b0;
    do_fetch(5'h07, 2);
    @(negedge clk);
    fetch_done_i = 1'b0;
    c = cyc;
    sbq.push_back('{1'b1, 2'd1, 0, 1, 1, c + TMO});
    @(negedge clk);
    wait_done();
    @(negedge clk);
    chk("error_held_idle", error, 1);
    start = 1'b1;
    wait_fetch();
    start = 1'b0;
    chk("error_cleared", error, 0);
    chk("err_code_cleared", err_code, 0);
    do_fetch(HALT, 2);
    sbq.push_back('{1'b0, 2'd0, 0, 1, 0, cyc + 1});
    @(negedge clk);
    fetch_done_i = 1'b0;
    @(negedge clk);

    // Endless program hits the instruction limit
    start = 1'b1;
    wait_fetch();
    start = 1'b0;
    for (int i = 0; i < MAXI; i++) begin
      do_fetch(5'h05 + 5'(i), 2);
      @(negedge clk);
      fetch_done_i = 1'b0;
      do_exec(3);
      if (i == MAXI - 1) sbq.push_back('{1'b1, 2'd2, MAXI, MAXI, MAXI, cyc + 1});
      @(negedge clk);
      exec_done_i = 1'b0;
    end
    repeat (5) @(negedge clk);
    chk("no_fetch_after_limit", nf, 0);
    chk("limit_count_held", instr_count, MAXI);

    // abort coinciding with exec_done_i on the second instruction
    start = 1'b1;
    wait_fetch();
    start = 1'b0;
    run_one(5'h09, 2, 3);
    do_fetch(5'h0a, 2);
    @(negedge clk);
    fetch_done_i = 1'b0;
    do_exec(4);
    abort = 1'b1;
    sbq.push_back('{1'b1, 2'd3, 1, 2, 2, cyc + 1});
    @(negedge clk);
    exec_done_i = 1'b0;
    abort = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_fetch_after_abort", nf, 0);
    chk("abort_count_held", instr_count, 1);

    // start while busy is ignored; reset mid WAIT_EXEC gives no done
    start = 1'b1;
    wait_fetch();
    start = 1'b0;
    run_one(5'h0c, 2, 3);
    do_fetch(5'h0d, 2);
    @(negedge clk);
    fetch_done_i = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ignored_fetch", fetch_en_o, 0);
    chk("start_ignored_busy", busy, 1);
    chk("count_before_reset", instr_count, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_done", done, 0);
    chk("midrun_rst_error", error, 0);
    chk("midrun_rst_count", instr_count, 0);
    chk("midrun_rst_exec_start", exec_start_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_after_reset", busy, 0);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at %0t, required finish", $time);
    $fatal(1, "bench timeout");
  end

endmodule
